fmul_wb_buffer: RTL

FMUL_WB_BUFFER -- requirements
Module: fmul_wb_buffer

---
 rtl/fmul_wb_buffer.sv | 77 +++++++
 1 files changed

// File: rtl/fmul_wb_buffer.sv
// fmul_wb_buffer: tag pipeline, credit control and in-order result FIFO around a fixed-latency FP multiplier.
// Define FMUL_WB_BYPASS_EN to let a completing result reach the CDB directly when the FIFO is empty.
module fmul_wb_buffer #(
  parameter int TAG_W = 6,
  parameter int DEPTH = 4,
  parameter int LAT   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [TAG_W-1:0] issue_tag,
  input  logic [31:0]      issue_a,
  input  logic [31:0]      issue_b,
  output logic             mul_start,
  output logic [31:0]      mul_a,
  output logic [31:0]      mul_b,
  input  logic             mul_done,
  input  logic [31:0]      mul_result,
  input  logic             mul_exc,
  output logic             cdb_valid,
  input  logic             cdb_ready,
  output logic [TAG_W-1:0] cdb_tag,
  output logic [31:0]      cdb_data,
  output logic             cdb_exc,
  input  logic             flush,
  output logic             seq_err
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = TAG_W + 33;
  logic [LAT-1:0]            vld, kill;
  logic [LAT-1:0][TAG_W-1:0] tg;
  logic [EW-1:0]             mem [DEPTH];
  logic [EW-1:0]             done_ent;
  logic [PW-1:0]             wp, rp;
  logic [CW-1:0]             cnt, cred;
  logic                      byp, push, pop, retire;
  assign mul_start   = issue_valid && issue_ready && !flush;
  assign mul_a       = issue_a;
  assign mul_b       = issue_b;
  assign issue_ready = cred < CW'(DEPTH);
  assign done_ent    = {tg[LAT-1], mul_result, mul_exc};
`ifdef FMUL_WB_BYPASS_EN
  assign byp = vld[LAT-1] && cnt == '0 && cdb_ready && !flush;
`else
  assign byp = 1'b0;
`endif
  assign push      = vld[LAT-1] && !byp && !flush;
  assign pop       = cnt != '0 && cdb_ready;
  assign cdb_valid = cnt != '0 || byp;
  assign retire    = cdb_valid && cdb_ready;
  assign {cdb_tag, cdb_data, cdb_exc} = byp ? done_ent : mem[rp];
  // kill shadows ops dropped by flush or reset so their late mul_done pulses are not errors
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      vld     <= '0;
      kill    <= '1;
      wp      <= '0;
      rp      <= '0;
      cnt     <= '0;
      cred    <= '0;
      seq_err <= 1'b0;
    end else begin
      vld     <= flush ? '0 : LAT'({vld, mul_start});
      kill    <= LAT'({kill | (flush ? vld : '0), 1'b0});
      seq_err <= seq_err || (mul_done != vld[LAT-1] && !kill[LAT-1]);
      wp      <= flush ? '0 : wp + PW'(push);
      rp      <= flush ? '0 : rp + PW'(pop);
      cnt     <= flush ? '0 : cnt + CW'(push) - CW'(pop);
      cred    <= flush ? '0 : cred + CW'(mul_start) - CW'(retire);
    end
  always_ff @(posedge clk) begin
    tg <= (LAT*TAG_W)'({tg, issue_tag});
    if (push) mem[wp] <= done_ent;
  end
endmodule
